// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the external interrupt controller.
// Register offsets are byte offsets into the load/store window.
package irq_ctrl_pkg;

    localparam int ID_W       = 6;
    localparam int PRIO_MAX_W = 8;

    localparam logic [11:0] OFF_PENDING   = 12'h000;
    localparam logic [11:0] OFF_ENABLE    = 12'h008;
    localparam logic [11:0] OFF_THRESH    = 12'h010;
    localparam logic [11:0] OFF_CLAIM     = 12'h018;
    localparam logic [11:0] OFF_PRIO_BASE = 12'h100;

    // Strict compare: equal priorities never displace an earlier (lower) ID.
    function automatic logic prio_gt(input logic [PRIO_MAX_W-1:0] a,
                                     input logic [PRIO_MAX_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: turns a sampled source into a one-deep pending bit,
// applying either edge or level set rules against claim clears.
module irq_gateway (
    input  logic clk,
    input  logic reset,
    input  logic src_q,
    input  logic mode,
    input  logic claim_hit,
    input  logic in_service,
    output logic pending
);

    logic src_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_d   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_d <= src_q;
            if (mode) begin
                // A fresh edge beats a same-cycle claim so it is never lost.
                pending <= (src_q & ~src_d) | (pending & ~claim_hit);
            end else begin
                // Level: claiming moves the source into service, which blocks re-set.
                pending <= ~claim_hit & (pending | (src_q & ~in_service));
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: per-source gateways, enable/priority/threshold
// filtering, a registered priority arbiter and a claim/complete register window.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_SRC   = 8,
    parameter int                 PRIO_W    = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter int                 ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [63:0]       cfg_wdata,
    input  logic              cfg_we,
    input  logic              cfg_re,
    output logic [63:0]       cfg_rdata,
    output logic              ext_irq,
    output logic [ID_W-1:0]   claim_id
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [PRIO_W-1:0]  threshold;
    logic [ID_W-1:0]    best_id;
    logic [ID_W-1:0]    best_id_n;
    logic [PRIO_W-1:0]  best_prio_n;
    logic [ADDR_W-1:0]  off;
    logic               claim;
    logic               complete;
    logic [63:0]        rdata_n;
    logic               unused_bits;

    assign off         = {cfg_addr[ADDR_W-1:3], 3'b000};
    assign claim       = cfg_re && (off == ADDR_W'(OFF_CLAIM));
    assign complete    = cfg_we && (off == ADDR_W'(OFF_CLAIM));
    assign claim_id    = best_id;
    assign unused_bits = ^{cfg_addr[2:0], cfg_wdata};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign claim_hit[g]    = claim && (best_id == ID_W'(g + 1));
        assign complete_hit[g] = complete && (cfg_wdata[ID_W-1:0] == ID_W'(g + 1));
        assign eligible[g]     = pending[g] & enable[g] & ~in_service[g] &
                                 prio_gt(PRIO_MAX_W'(prio[g]), PRIO_MAX_W'(threshold));

        irq_gateway u_gw (
            .clk        (clk),
            .reset      (reset),
            .src_q      (src_q[g]),
            .mode       (EDGE_MASK[g]),
            .claim_hit  (claim_hit[g]),
            .in_service (in_service[g]),
            .pending    (pending[g])
        );
    end

    // Ascending scan with a strict compare resolves ties to the lowest ID.
    always_comb begin
        best_id_n   = '0;
        best_prio_n = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && prio_gt(PRIO_MAX_W'(prio[i]), PRIO_MAX_W'(best_prio_n))) begin
                best_id_n   = ID_W'(i + 1);
                best_prio_n = prio[i];
            end
        end
    end

    always_comb begin
        rdata_n = '0;
        if (off == ADDR_W'(OFF_PENDING)) rdata_n = 64'({pending, 1'b0});
        if (off == ADDR_W'(OFF_ENABLE))  rdata_n = 64'({enable, 1'b0});
        if (off == ADDR_W'(OFF_THRESH))  rdata_n = 64'(threshold);
        if (off == ADDR_W'(OFF_CLAIM))   rdata_n = 64'(best_id);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (off == ADDR_W'(OFF_PRIO_BASE) + ADDR_W'(8 * i)) rdata_n = 64'(prio[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q      <= '0;
            enable     <= '0;
            threshold  <= '0;
            in_service <= '0;
            best_id    <= '0;
            ext_irq    <= 1'b0;
            cfg_rdata  <= '0;
            for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
        end else begin
            src_q <= irq_src;
            if (cfg_we) begin
                if (off == ADDR_W'(OFF_ENABLE)) enable    <= cfg_wdata[NUM_SRC:1];
                if (off == ADDR_W'(OFF_THRESH)) threshold <= cfg_wdata[PRIO_W-1:0];
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (off == ADDR_W'(OFF_PRIO_BASE) + ADDR_W'(8 * i)) prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
            // A claim of the same ID being completed keeps it in service.
            in_service <= (in_service & ~complete_hit) | claim_hit;
            best_id    <= best_id_n;
            ext_irq    <= (best_id_n != '0);
            if (cfg_re) cfg_rdata <= rdata_n;
        end
    end

endmodule
